axi_slave_burst_sched: RTL and testbench

- Slave-side burst scheduler for the AXI4_SLAVE bus. Accepts AW/W write bursts and AR read bursts and shares one single-port synchronous SRAM between them, using round-robin arbitration. Generates B and R responses, gated by the wr_rsp_en/rd_rsp_en response enables.
- Sits between the AXI4_SLAVE interface signals and the FIFO/memory datapath. One burst is in flight at a time.

---
 rtl/axi_slave_pkg.sv | 53 +++++
 rtl/axi_slave_burst_sched_if.sv | 66 ++++++
 rtl/axi_burst_addr_gen.sv | 33 +++
 rtl/axi_slave_burst_sched.sv | 166 ++++++++++++++++
 tb/tb_axi_slave_burst_sched.sv | 349 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_slave_pkg.sv
// Shared types and constants for the AXI slave burst scheduler.
package axi_slave_pkg;

  localparam int unsigned ID_W   = 4;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned LEN_W  = 4;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned MEM_AW = 10;
  localparam int unsigned OFF_W  = $clog2(STRB_W);

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    WR_DATA,
    WR_RESP,
    RD_REQ,
    RD_WAIT,
    RD_DATA
  } state_t;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
    logic [2:0]        size;
    logic [1:0]        burst;
    logic              err;
  } burst_ctx_t;

  // Byte address lies beyond the last SRAM word.
  function automatic logic addr_oor(input logic [ADDR_W-1:0] a);
    return (a >> (MEM_AW + OFF_W)) != '0;
  endfunction

  // Burst attributes that make the whole burst unserviceable.
  function automatic logic accept_err(input logic [1:0]        burst,
                                      input logic [2:0]        size,
                                      input logic [LEN_W-1:0]  len,
                                      input logic [ADDR_W-1:0] addr);
    logic wrap_len_ok;
    wrap_len_ok = (len == LEN_W'(1)) || (len == LEN_W'(3)) ||
                  (len == LEN_W'(7)) || (len == LEN_W'(15));
    return (burst == 2'b11) || (size > 3'(OFF_W)) || addr_oor(addr) ||
           ((burst == BURST_WRAP) && !wrap_len_ok);
  endfunction

endpackage

// File: rtl/axi_slave_burst_sched_if.sv
// AXI4 slave-side channel bundle (AW/W/B/AR/R).
interface axi_slave_burst_sched_if;
  import axi_slave_pkg::*;

  logic [ID_W-1:0]   AWID;
  logic [ADDR_W-1:0] AWADDR;
  logic [LEN_W-1:0]  AWLEN;
  logic [2:0]        AWSIZE;
  logic [1:0]        AWBURST;
  logic              AWVALID;
  logic              AWREADY;

  logic [ID_W-1:0]   WID;
  logic [DATA_W-1:0] WDATA;
  logic [STRB_W-1:0] WSTRB;
  logic              WLAST;
  logic              WVALID;
  logic              WREADY;

  logic [ID_W-1:0]   BID;
  logic [1:0]        BRESP;
  logic              BVALID;
  logic              BREADY;

  logic [ID_W-1:0]   ARID;
  logic [ADDR_W-1:0] ARADDR;
  logic [LEN_W-1:0]  ARLEN;
  logic [2:0]        ARSIZE;
  logic [1:0]        ARBURST;
  logic              ARVALID;
  logic              ARREADY;

  logic [ID_W-1:0]   RID;
  logic [DATA_W-1:0] RDATA;
  logic [1:0]        RRESP;
  logic              RLAST;
  logic              RVALID;
  logic              RREADY;

  modport slave (
    input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    output AWREADY,
    input  WID, WDATA, WSTRB, WLAST, WVALID,
    output WREADY,
    output BID, BRESP, BVALID,
    input  BREADY,
    input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
    output ARREADY,
    output RID, RDATA, RRESP, RLAST, RVALID,
    input  RREADY
  );

  modport master (
    output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    input  AWREADY,
    output WID, WDATA, WSTRB, WLAST, WVALID,
    input  WREADY,
    input  BID, BRESP, BVALID,
    output BREADY,
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
    input  ARREADY,
    input  RID, RDATA, RRESP, RLAST, RVALID,
    output RREADY
  );

endinterface

// File: rtl/axi_burst_addr_gen.sv
// Next-beat byte address for FIXED/INCR/WRAP bursts, with SRAM range flag.
module axi_burst_addr_gen
  import axi_slave_pkg::*;
(
  input  logic [ADDR_W-1:0] addr,
  input  logic [2:0]        size,
  input  logic [LEN_W-1:0]  len,
  input  logic [1:0]        burst,
  output logic [ADDR_W-1:0] next_addr,
  output logic              oor
);

  logic [ADDR_W-1:0] step;
  logic [ADDR_W-1:0] win;
  logic [ADDR_W-1:0] mask;
  logic [ADDR_W-1:0] inc;

  // WRAP keeps the upper bits of the aligned window and wraps the low bits.
  always_comb begin
    step = ADDR_W'(1) << size;
    win  = (ADDR_W'(len) + ADDR_W'(1)) << size;
    mask = win - ADDR_W'(1);
    inc  = addr + step;
    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_INCR:  next_addr = inc;
      BURST_WRAP:  next_addr = (addr & ~mask) | (inc & mask);
      default:     next_addr = addr;
    endcase
    oor = (burst == BURST_INCR) && addr_oor(inc);
  end

endmodule

// File: rtl/axi_slave_burst_sched.sv
// Single-outstanding AXI4 slave burst scheduler sharing one SRAM port.
module axi_slave_burst_sched
  import axi_slave_pkg::*;
(
  input  logic                  ACLK,
  input  logic                  ARESETn,
  axi_slave_burst_sched_if.slave bus,
  input  logic                  wr_rsp_en,
  input  logic                  rd_rsp_en,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [MEM_AW-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [STRB_W-1:0]     mem_wstrb,
  input  logic [DATA_W-1:0]     mem_rdata
);

  state_t            state;
  burst_ctx_t        ctx;
  logic [LEN_W-1:0]  beat;
  logic              wr_prio;
  logic              awready_q, arready_q, wready_q;
  logic              bvalid_q;
  logic [ID_W-1:0]   bid_q;
  logic [1:0]        bresp_q;
  logic              rvalid_q, rlast_q;
  logic [ID_W-1:0]   rid_q;
  logic [DATA_W-1:0] rdata_q;
  logic [1:0]        rresp_q;

  logic [ADDR_W-1:0] nxt_addr;
  logic              nxt_oor;
  logic              w_fire, w_beat_err, r_fire, last_beat;

  axi_burst_addr_gen u_addr_gen (
    .addr      (ctx.addr),
    .size      (ctx.size),
    .len       (ctx.len),
    .burst     (ctx.burst),
    .next_addr (nxt_addr),
    .oor       (nxt_oor)
  );

  assign bus.AWREADY = awready_q;
  assign bus.ARREADY = arready_q;
  assign bus.WREADY  = wready_q;
  assign bus.BVALID  = bvalid_q;
  assign bus.BID     = bid_q;
  assign bus.BRESP   = bresp_q;
  assign bus.RVALID  = rvalid_q;
  assign bus.RID     = rid_q;
  assign bus.RDATA   = rdata_q;
  assign bus.RRESP   = rresp_q;
  assign bus.RLAST   = rlast_q;

  // SRAM strobe follows the W handshake / read launch in the same cycle.
  always_comb begin
    last_beat  = (beat == ctx.len);
    w_fire     = (state == WR_DATA) && wready_q && bus.WVALID;
    w_beat_err = (bus.WID != ctx.id) || (bus.WLAST != last_beat);
    r_fire     = (state == RD_REQ) && rd_rsp_en;
    mem_req    = !ctx.err && ((w_fire && !w_beat_err) || r_fire);
    mem_we     = mem_req && (state == WR_DATA);
    mem_addr   = mem_req ? ctx.addr[MEM_AW+OFF_W-1:OFF_W] : '0;
    mem_wdata  = mem_we ? bus.WDATA : '0;
    mem_wstrb  = mem_we ? bus.WSTRB : '0;
  end

  // Burst FSM: arbitration, beat sequencing and registered responses.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state     <= IDLE;
      ctx       <= '0;
      beat      <= '0;
      wr_prio   <= 1'b1;
      awready_q <= 1'b0;
      arready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= '0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rid_q     <= '0;
      rdata_q   <= '0;
      rresp_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (awready_q) begin
            awready_q <= 1'b0;
            wready_q  <= 1'b1;
            state     <= WR_DATA;
          end else if (arready_q) begin
            arready_q <= 1'b0;
            state     <= RD_REQ;
          end else if (bus.AWVALID && (!bus.ARVALID || wr_prio)) begin
            awready_q <= 1'b1;
            beat      <= '0;
            ctx       <= '{id: bus.AWID, addr: bus.AWADDR, len: bus.AWLEN,
                           size: bus.AWSIZE, burst: bus.AWBURST,
                           err: accept_err(bus.AWBURST, bus.AWSIZE, bus.AWLEN, bus.AWADDR)};
            if (bus.ARVALID) wr_prio <= 1'b0;
          end else if (bus.ARVALID) begin
            arready_q <= 1'b1;
            beat      <= '0;
            ctx       <= '{id: bus.ARID, addr: bus.ARADDR, len: bus.ARLEN,
                           size: bus.ARSIZE, burst: bus.ARBURST,
                           err: accept_err(bus.ARBURST, bus.ARSIZE, bus.ARLEN, bus.ARADDR)};
            if (bus.AWVALID) wr_prio <= 1'b1;
          end
        end
        WR_DATA: begin
          if (w_fire) begin
            ctx.addr <= nxt_addr;
            if (w_beat_err || (nxt_oor && !last_beat)) ctx.err <= 1'b1;
            if (last_beat) begin
              wready_q <= 1'b0;
              state    <= WR_RESP;
            end else begin
              beat <= beat + LEN_W'(1);
            end
          end
        end
        WR_RESP: begin
          if (!bvalid_q) begin
            if (wr_rsp_en) begin
              bvalid_q <= 1'b1;
              bid_q    <= ctx.id;
              bresp_q  <= ctx.err ? RESP_SLVERR : RESP_OKAY;
            end
          end else if (bus.BREADY) begin
            bvalid_q <= 1'b0;
            state    <= IDLE;
          end
        end
        RD_REQ: begin
          if (rd_rsp_en) state <= RD_WAIT;
        end
        RD_WAIT: begin
          rvalid_q <= 1'b1;
          rdata_q  <= ctx.err ? '0 : mem_rdata;
          rid_q    <= ctx.id;
          rresp_q  <= ctx.err ? RESP_SLVERR : RESP_OKAY;
          rlast_q  <= last_beat;
          state    <= RD_DATA;
        end
        RD_DATA: begin
          if (bus.RREADY) begin
            rvalid_q <= 1'b0;
            if (rlast_q) begin
              state <= IDLE;
            end else begin
              beat     <= beat + LEN_W'(1);
              ctx.addr <= nxt_addr;
              if (nxt_oor) ctx.err <= 1'b1;
              state    <= RD_REQ;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_slave_burst_sched.sv
// Scoreboard bench for axi_slave_burst_sched with a behavioural SRAM.
module tb_axi_slave_burst_sched;
  import axi_slave_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic wr_rsp_en, rd_rsp_en;
  logic mem_req, mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic [STRB_W-1:0] mem_wstrb;

  always #5 clk = ~clk;

  axi_slave_burst_sched_if bus ();

  axi_slave_burst_sched dut (
    .ACLK      (clk),
    .ARESETn   (rst_n),
    .bus       (bus),
    .wr_rsp_en (wr_rsp_en),
    .rd_rsp_en (rd_rsp_en),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_rdata (mem_rdata)
  );

  typedef struct { logic [MEM_AW-1:0] addr; logic [DATA_W-1:0] data; logic [STRB_W-1:0] strb; } mw_t;
  typedef struct { logic [ID_W-1:0] id; logic [1:0] resp; } b_t;
  typedef struct { logic [ID_W-1:0] id; logic [DATA_W-1:0] data; logic [1:0] resp; logic last; } r_t;

  mw_t mw_q[$];
  logic [MEM_AW-1:0] mr_q[$];
  b_t  b_q[$];
  r_t  r_q[$];

  logic [DATA_W-1:0] sram    [0:(1<<MEM_AW)-1];
  logic [DATA_W-1:0] ref_mem [0:(1<<MEM_AW)-1];

  int n_cmp = 0;
  int n_err = 0;
  int unsigned cyc = 0;
  int unsigned aw_cyc, ar_cyc;

  mw_t mon_w;
  b_t  mon_b;
  r_t  mon_r;
  logic [MEM_AW-1:0] mon_ra;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference address sequencing, written in division/modulo form.
  function automatic logic [31:0] tb_next(input logic [31:0] a, input logic [2:0] size,
                                          input logic [3:0] len, input logic [1:0] burst);
    logic [31:0] stp, wb, base;
    stp = 32'd1 << size;
    case (burst)
      2'b01: return a + stp;
      2'b10: begin
        wb   = (32'(len) + 32'd1) * stp;
        base = (a / wb) * wb;
        return base + ((a - base + stp) % wb);
      end
      default: return a;
    endcase
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural single-port SRAM with one-cycle read latency.
  always @(posedge clk) begin
    if (mem_req) begin
      if (mem_we) begin
        for (int k = 0; k < int'(STRB_W); k++)
          if (mem_wstrb[k]) sram[mem_addr][k*8 +: 8] <= mem_wdata[k*8 +: 8];
      end else begin
        mem_rdata <= sram[mem_addr];
      end
    end
  end

  // Output monitor: pops the scoreboard on every SRAM access and B/R handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_req && mem_we) begin
        check("mem_wr_expected", 64'(mw_q.size() > 0), 64'(1));
        if (mw_q.size() > 0) begin
          mon_w = mw_q.pop_front();
          check("mem_waddr", 64'(mem_addr), 64'(mon_w.addr));
          check("mem_wdata", mem_wdata, mon_w.data);
          check("mem_wstrb", 64'(mem_wstrb), 64'(mon_w.strb));
        end
      end
      if (mem_req && !mem_we) begin
        check("mem_rd_expected", 64'(mr_q.size() > 0), 64'(1));
        if (mr_q.size() > 0) begin
          mon_ra = mr_q.pop_front();
          check("mem_raddr", 64'(mem_addr), 64'(mon_ra));
        end
      end
      if (bus.BVALID && bus.BREADY) begin
        check("b_expected", 64'(b_q.size() > 0), 64'(1));
        if (b_q.size() > 0) begin
          mon_b = b_q.pop_front();
          check("bid", 64'(bus.BID), 64'(mon_b.id));
          check("bresp", 64'(bus.BRESP), 64'(mon_b.resp));
        end
      end
      if (bus.RVALID && bus.RREADY) begin
        check("r_expected", 64'(r_q.size() > 0), 64'(1));
        if (r_q.size() > 0) begin
          mon_r = r_q.pop_front();
          check("rid", 64'(bus.RID), 64'(mon_r.id));
          check("rdata", bus.RDATA, mon_r.data);
          check("rresp", 64'(bus.RRESP), 64'(mon_r.resp));
          check("rlast", 64'(bus.RLAST), 64'(mon_r.last));
        end
      end
    end
  end

  // Write burst: the first ok_beats beats are expected in SRAM; early_last>=0 moves WLAST.
  task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input int ok_beats,
                          input int early_last, input bit exp_err, input int rsp_hold);
    logic [DATA_W-1:0] wd [16];
    logic [STRB_W-1:0] ws [16];
    logic [31:0] a;
    logic [MEM_AW-1:0] idx;
    int t;
    a = addr;
    for (int b = 0; b <= int'(len); b++) begin
      wd[b] = {$urandom, $urandom};
      ws[b] = STRB_W'($urandom) | STRB_W'(1);
      if (b < ok_beats) begin
        idx = a[MEM_AW+OFF_W-1:OFF_W];
        mw_q.push_back('{idx, wd[b], ws[b]});
        for (int k = 0; k < int'(STRB_W); k++)
          if (ws[b][k]) ref_mem[idx][k*8 +: 8] = wd[b][k*8 +: 8];
      end
      a = tb_next(a, size, len, burst);
    end
    b_q.push_back('{id, exp_err ? RESP_SLVERR : RESP_OKAY});
    if (rsp_hold > 0) wr_rsp_en = 1'b0;
    bus.AWID = id; bus.AWADDR = addr; bus.AWLEN = len; bus.AWSIZE = size; bus.AWBURST = burst;
    bus.AWVALID = 1'b1;
    t = 0;
    while (!bus.AWREADY && t < 200) begin step(); t++; end
    check("aw_timeout", 64'(t < 200), 64'(1));
    aw_cyc = cyc;
    step();
    bus.AWVALID = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      bus.WID = id; bus.WDATA = wd[b]; bus.WSTRB = ws[b];
      bus.WLAST = (early_last >= 0) ? (b == early_last) : (b == int'(len));
      bus.WVALID = 1'b1;
      t = 0;
      while (!bus.WREADY && t < 100) begin step(); t++; end
      step();
    end
    bus.WVALID = 1'b0;
    bus.WLAST = 1'b0;
    if (rsp_hold > 0) begin
      repeat (rsp_hold) begin
        check("bvalid_gated", 64'(bus.BVALID), 64'(0));
        step();
      end
      wr_rsp_en = 1'b1;
      step();
      check("bvalid_rise", 64'(bus.BVALID), 64'(1));
    end
    t = 0;
    while (!bus.BVALID && t < 100) begin step(); t++; end
    check("b_timeout", 64'(t < 100), 64'(1));
    step();
  endtask

  task automatic push_read_exp(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                               input logic [2:0] size, input logic [1:0] burst, input int ok_beats);
    logic [31:0] a;
    logic [MEM_AW-1:0] idx;
    a = addr;
    for (int b = 0; b <= int'(len); b++) begin
      idx = a[MEM_AW+OFF_W-1:OFF_W];
      if (b < ok_beats) begin
        mr_q.push_back(idx);
        r_q.push_back('{id, ref_mem[idx], RESP_OKAY, b == int'(len)});
      end else begin
        r_q.push_back('{id, '0, RESP_SLVERR, b == int'(len)});
      end
      a = tb_next(a, size, len, burst);
    end
  endtask

  task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int t;
    bus.ARID = id; bus.ARADDR = addr; bus.ARLEN = len; bus.ARSIZE = size; bus.ARBURST = burst;
    bus.ARVALID = 1'b1;
    t = 0;
    while (!bus.ARREADY && t < 200) begin step(); t++; end
    check("ar_timeout", 64'(t < 200), 64'(1));
    ar_cyc = cyc;
    step();
    bus.ARVALID = 1'b0;
  endtask

  // Collect n R beats; optionally check 3-cycle spacing and stall one beat for 5 cycles.
  task automatic collect_r(input int n, input bit chk_gap, input int stall_beat);
    int t;
    int unsigned last_c;
    logic [DATA_W-1:0] exp_d;
    last_c = 0;
    for (int b = 0; b < n; b++) begin
      if (b == stall_beat) bus.RREADY = 1'b0;
      t = 0;
      while (!bus.RVALID && t < 100) begin step(); t++; end
      check("r_timeout", 64'(t < 100), 64'(1));
      if (chk_gap && b > 0) check("r_gap", 64'(cyc - last_c), 64'(3));
      last_c = cyc;
      if (b == stall_beat) begin
        exp_d = (r_q.size() > 0) ? r_q[0].data : '0;
        repeat (5) begin
          step();
          check("r_stall_valid", 64'(bus.RVALID), 64'(1));
          check("r_stall_data", bus.RDATA, exp_d);
        end
        bus.RREADY = 1'b1;
      end
      step();
    end
  endtask

  task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [2:0] size, input logic [1:0] burst, input int ok_beats,
                         input bit chk_gap, input int stall_beat);
    push_read_exp(id, addr, len, size, burst, ok_beats);
    send_ar(id, addr, len, size, burst);
    collect_r(int'(len) + 1, chk_gap, stall_beat);
  endtask

  initial begin
    int t;
    for (int i = 0; i < (1 << MEM_AW); i++) begin
      sram[i]    = {$urandom, $urandom};
      ref_mem[i] = sram[i];
    end
    bus.AWID = '0; bus.AWADDR = '0; bus.AWLEN = '0; bus.AWSIZE = '0; bus.AWBURST = '0; bus.AWVALID = 1'b0;
    bus.WID = '0; bus.WDATA = '0; bus.WSTRB = '0; bus.WLAST = 1'b0; bus.WVALID = 1'b0;
    bus.ARID = '0; bus.ARADDR = '0; bus.ARLEN = '0; bus.ARSIZE = '0; bus.ARBURST = '0; bus.ARVALID = 1'b0;
    bus.BREADY = 1'b1; bus.RREADY = 1'b1;
    wr_rsp_en = 1'b1; rd_rsp_en = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check("rst_awready", 64'(bus.AWREADY), 64'(0));
    check("rst_arready", 64'(bus.ARREADY), 64'(0));
    check("rst_wready",  64'(bus.WREADY),  64'(0));
    check("rst_bvalid",  64'(bus.BVALID),  64'(0));
    check("rst_rvalid",  64'(bus.RVALID),  64'(0));
    check("rst_mem_req", 64'(mem_req),     64'(0));
    rst_n = 1'b1;
    step();

    // Collisions from reset: write, then read, then write again.
    fork
      do_write(4'h1, 32'h100, 4'd3, 3'd3, BURST_INCR, 4, -1, 1'b0, 0);
      do_read (4'h2, 32'h200, 4'd1, 3'd3, BURST_INCR, 2, 1'b0, -1);
    join
    check("coll1_write_first", 64'(aw_cyc < ar_cyc), 64'(1));
    fork
      do_write(4'h3, 32'h300, 4'd1, 3'd3, BURST_INCR, 2, -1, 1'b0, 0);
      do_read (4'h4, 32'h400, 4'd1, 3'd3, BURST_INCR, 2, 1'b0, -1);
    join
    check("coll2_write_first", 64'(aw_cyc < ar_cyc), 64'(0));
    fork
      do_write(4'h5, 32'h500, 4'd0, 3'd3, BURST_INCR, 1, -1, 1'b0, 0);
      do_read (4'h6, 32'h600, 4'd0, 3'd3, BURST_INCR, 1, 1'b0, -1);
    join
    check("coll3_write_first", 64'(aw_cyc < ar_cyc), 64'(1));

    // Single write to words 2..5 and readback at one beat per 3 cycles.
    do_write(4'h9, 32'h10, 4'd3, 3'd3, BURST_INCR, 4, -1, 1'b0, 0);
    do_read (4'ha, 32'h10, 4'd3, 3'd3, BURST_INCR, 4, 1'b1, -1);

    // WRAP 0x38 -> words 7,4,5,6; WRAP with LEN=2 is rejected.
    do_write(4'hb, 32'h38, 4'd3, 3'd3, BURST_WRAP, 4, -1, 1'b0, 0);
    do_read (4'hb, 32'h38, 4'd3, 3'd3, BURST_WRAP, 4, 1'b0, -1);
    do_read (4'hc, 32'h38, 4'd2, 3'd3, BURST_WRAP, 0, 1'b0, -1);
    do_write(4'hc, 32'h38, 4'd2, 3'd3, BURST_WRAP, 0, -1, 1'b1, 0);

    // Response gating and R stall.
    do_write(4'hd, 32'h80, 4'd3, 3'd3, BURST_INCR, 4, -1, 1'b0, 10);
    do_read (4'hd, 32'h80, 4'd3, 3'd3, BURST_INCR, 4, 1'b0, 2);

    // Error cases: reserved burst, early WLAST, INCR running off the top, start out of range.
    do_write(4'he, 32'h90, 4'd3, 3'd3, 2'b11, 0, -1, 1'b1, 0);
    do_read (4'he, 32'h90, 4'd1, 3'd3, 2'b11, 0, 1'b0, -1);
    do_write(4'hf, 32'hA0, 4'd3, 3'd3, BURST_INCR, 1, 1, 1'b1, 0);
    do_write(4'h7, 32'h1FF8, 4'd1, 3'd3, BURST_INCR, 1, -1, 1'b1, 0);
    do_read (4'h7, 32'h1FF8, 4'd1, 3'd3, BURST_INCR, 1, 1'b0, -1);
    do_read (4'h8, 32'h2000, 4'd0, 3'd3, BURST_INCR, 0, 1'b0, -1);
    do_read (4'h8, 32'h40, 4'd0, 3'd4, BURST_INCR, 0, 1'b0, -1);

    // Reset in the middle of a read aborts it; the next read is served normally.
    push_read_exp(4'h5, 32'h10, 4'd3, 3'd3, BURST_INCR, 4);
    send_ar(4'h5, 32'h10, 4'd3, 3'd3, BURST_INCR);
    collect_r(1, 1'b0, -1);
    t = 0;
    while (!bus.RVALID && t < 100) begin step(); t++; end
    check("rst_mid_timeout", 64'(t < 100), 64'(1));
    rst_n = 1'b0;
    #1;
    check("rst_mid_rvalid", 64'(bus.RVALID), 64'(0));
    check("rst_mid_state", 64'(dut.state), 64'(IDLE));
    r_q.delete();
    mr_q.delete();
    step();
    step();
    rst_n = 1'b1;
    step();
    do_read(4'h6, 32'h10, 4'd3, 3'd3, BURST_INCR, 4, 1'b1, -1);

    repeat (5) step();
    check("mw_q_empty", 64'(mw_q.size()), 64'(0));
    check("mr_q_empty", 64'(mr_q.size()), 64'(0));
    check("b_q_empty",  64'(b_q.size()),  64'(0));
    check("r_q_empty",  64'(r_q.size()),  64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
